mb_r8_pipe: RTL and testbench

MB_R8_PIPE -- requirements
Module: mb_r8_pipe

---
 rtl/mb_r8_pipe.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_mb_r8_pipe.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mb_r8_pipe.sv
// ---------------------------------------------------------------------------
// mb_r8_pipe
// Three-stage pipelined radix-8 Booth multiplier with valid/ready handshakes.
// It handles signed or unsigned operands, selected per operation.
//
//   Stage 1 : Booth recoding of mx into one-hot digit selects, and forming
//             3*my.
//   Stage 2 : reduces the partial products to a sum/carry pair with a
//             carry-save chain.
//   Stage 3 : the final carry-propagate add into the product register.
//
// Ports
//   CLK        sole clock, all state updates on the rising edge
//   RST        asynchronous, active-low reset
//   in_valid   operand pair valid
//   in_ready   block accepts operands this cycle
//   sgn        1 = two's-complement operands, 0 = unsigned
//   mx         multiplicand (Booth-recoded operand), WIDTH bits
//   my         multiplier operand, WIDTH bits
//   out_valid  product valid
//   out_ready  downstream accepts the product
//   product    full 2*WIDTH-bit product
//   done_cnt   count of delivered products; saturates at its maximum value
// ---------------------------------------------------------------------------
module mb_r8_pipe #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   mx,
    input  logic [WIDTH-1:0]   my,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic [CNTW-1:0]    done_cnt
);

    // Number of radix-8 digits. The recoding window is those digits plus the
    // implicit zero below the LSB. It always covers the one-bit-extended mx.
    localparam int NG = (WIDTH + 3) / 3;
    localparam int PW = 2 * WIDTH;
    localparam int YW = WIDTH + 2;
    localparam int XW = 3 * NG + 1;

    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    // Handshake
    logic en;
    logic accept;

    // Stage 1 registers
    logic          s1_valid_q, s1_valid_d;
    logic          s1_sgn_q,   s1_sgn_d;
    logic [YW-1:0] s1_y_q,     s1_y_d;
    logic [YW-1:0] s1_ty_q,    s1_ty_d;
    logic [NG-1:0] s1_one_q,   s1_one_d;
    logic [NG-1:0] s1_two_q,   s1_two_d;
    logic [NG-1:0] s1_three_q, s1_three_d;
    logic [NG-1:0] s1_four_q,  s1_four_d;
    logic [NG-1:0] s1_neg_q,   s1_neg_d;

    // Stage 2 registers
    logic          s2_valid_q, s2_valid_d;
    logic [PW-1:0] s2_sum_q,   s2_sum_d;
    logic [PW-1:0] s2_car_q,   s2_car_d;

    // Stage 3 / output registers
    logic            out_valid_q, out_valid_d;
    logic [PW-1:0]   product_q,   product_d;
    logic [CNTW-1:0] done_cnt_q,  done_cnt_d;

    // Stage 1 combinational signals
    logic [XW-2:0] mx_ext;
    logic [XW-1:0] xwin;
    logic [YW-1:0] my_ext;
    logic [YW-1:0] tmy;
    logic [NG-1:0] r_one, r_two, r_three, r_four, r_neg;

    // Stage 2 combinational signals
    logic [PW-1:0] y1_w, y2_w, y3_w, y4_w;
    logic [PW-1:0] pp, cs_s, cs_c, cs_t, corr;

    // The whole pipeline freezes only when a finished product is waiting
    // and downstream is not taking it. in_ready is also forced low while
    // reset is asserted.
    assign en        = !(out_valid_q && !out_ready);
    assign in_ready  = en && RST;
    assign accept    = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign done_cnt  = done_cnt_q;

    // Booth recoding. Each 4-bit window b3 b2 b1 b0 has the value
    // -4*b3 + 2*b2 + b1 + b0. That value is recoded to a one-hot magnitude
    // and a negate flag. The pattern 1111 is "minus zero", so it stays a
    // plain zero with no negation.
    always_comb begin
        mx_ext  = {{(XW-1-WIDTH){sgn & mx[WIDTH-1]}}, mx};
        xwin    = {mx_ext, 1'b0};
        my_ext  = {{2{sgn & my[WIDTH-1]}}, my};
        tmy     = my_ext + {my_ext[YW-2:0], 1'b0};
        r_one   = '0;
        r_two   = '0;
        r_three = '0;
        r_four  = '0;
        r_neg   = '0;
        for (int i = 0; i < NG; i++) begin
            case (xwin[3*i +: 4])
                4'b0001, 4'b0010: r_one[i] = 1'b1;
                4'b0011, 4'b0100: r_two[i] = 1'b1;
                4'b0101, 4'b0110: r_three[i] = 1'b1;
                4'b0111:          r_four[i] = 1'b1;
                4'b1000: begin
                    r_four[i] = 1'b1;
                    r_neg[i]  = 1'b1;
                end
                4'b1001, 4'b1010: begin
                    r_three[i] = 1'b1;
                    r_neg[i]   = 1'b1;
                end
                4'b1011, 4'b1100: begin
                    r_two[i] = 1'b1;
                    r_neg[i] = 1'b1;
                end
                4'b1101, 4'b1110: begin
                    r_one[i] = 1'b1;
                    r_neg[i] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Stage 1 register inputs. The register is loaded only on an accepted
    // operand pair. A bubble clears the valid bit but leaves the data as it
    // was.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sgn_d   = s1_sgn_q;
        s1_y_d     = s1_y_q;
        s1_ty_d    = s1_ty_q;
        s1_one_d   = s1_one_q;
        s1_two_d   = s1_two_q;
        s1_three_d = s1_three_q;
        s1_four_d  = s1_four_q;
        s1_neg_d   = s1_neg_q;
        if (en) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_sgn_d   = sgn;
                s1_y_d     = my_ext;
                s1_ty_d    = tmy;
                s1_one_d   = r_one;
                s1_two_d   = r_two;
                s1_three_d = r_three;
                s1_four_d  = r_four;
                s1_neg_d   = r_neg;
            end
        end
    end

    // Multiples of my, sign-extended to the product width. For unsigned
    // operations 3*my can set the top bit of the YW-bit field. For that
    // reason the extension uses the operation's own sgn and not just the MSB.
    always_comb begin
        y1_w = {{(PW-YW){s1_sgn_q & s1_y_q[YW-1]}}, s1_y_q};
        y3_w = {{(PW-YW){s1_sgn_q & s1_ty_q[YW-1]}}, s1_ty_q};
        y2_w = y1_w << 1;
        y4_w = y1_w << 2;
    end

    // Carry-save reduction of the partial products. A negative digit
    // contributes the inverted multiple. Its "+1" is collected in corr, at
    // the digit's LSB weight, and folded in as one extra addend at the end.
    // All arithmetic is modulo 2^PW.
    always_comb begin
        pp   = '0;
        cs_s = '0;
        cs_c = '0;
        cs_t = '0;
        corr = '0;
        for (int i = 0; i < NG; i++) begin
            pp = '0;
            if (s1_one_q[i]) begin
                pp = y1_w;
            end else if (s1_two_q[i]) begin
                pp = y2_w;
            end else if (s1_three_q[i]) begin
                pp = y3_w;
            end else if (s1_four_q[i]) begin
                pp = y4_w;
            end
            if (s1_neg_q[i]) begin
                pp           = ~pp;
                corr[3*i]    = 1'b1;
            end
            pp   = pp << (3 * i);
            cs_t = cs_s ^ cs_c ^ pp;
            cs_c = ((cs_s & cs_c) | (cs_s & pp) | (cs_c & pp)) << 1;
            cs_s = cs_t;
        end
        cs_t = cs_s ^ cs_c ^ corr;
        cs_c = ((cs_s & cs_c) | (cs_s & corr) | (cs_c & corr)) << 1;
        cs_s = cs_t;
    end

    // Stage 2 register inputs
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sum_d   = s2_sum_q;
        s2_car_d   = s2_car_q;
        if (en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_d = cs_s;
                s2_car_d = cs_c;
            end
        end
    end

    // Final add. The product register only changes when a real result
    // arrives, so it holds its last value through bubbles and stalls.
    always_comb begin
        out_valid_d = out_valid_q;
        product_d   = product_q;
        if (en) begin
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                product_d = s2_sum_q + s2_car_q;
            end
        end
    end

    // Delivered-product counter, saturating at all-ones
    always_comb begin
        done_cnt_d = done_cnt_q;
        if (out_valid_q && out_ready && (done_cnt_q != CNT_MAX)) begin
            done_cnt_d = done_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_valid_q  <= 1'b0;
            s1_sgn_q    <= 1'b0;
            s1_y_q      <= '0;
            s1_ty_q     <= '0;
            s1_one_q    <= '0;
            s1_two_q    <= '0;
            s1_three_q  <= '0;
            s1_four_q   <= '0;
            s1_neg_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_sum_q    <= '0;
            s2_car_q    <= '0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            done_cnt_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sgn_q    <= s1_sgn_d;
            s1_y_q      <= s1_y_d;
            s1_ty_q     <= s1_ty_d;
            s1_one_q    <= s1_one_d;
            s1_two_q    <= s1_two_d;
            s1_three_q  <= s1_three_d;
            s1_four_q   <= s1_four_d;
            s1_neg_q    <= s1_neg_d;
            s2_valid_q  <= s2_valid_d;
            s2_sum_q    <= s2_sum_d;
            s2_car_q    <= s2_car_d;
            out_valid_q <= out_valid_d;
            product_q   <= product_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

endmodule

// File: tb/tb_mb_r8_pipe.sv
// ---------------------------------------------------------------------------
// tb_mb_r8_pipe
// Self-checking bench for mb_r8_pipe.
//   - One WIDTH=16 / CNTW=16 instance covers reset, latency, the signed
//     corner cases, stalls, random streams and reset while operations are
//     in flight.
//   - Four WIDTH=8 / CNTW=4 instances share an exhaustive sweep. Each one
//     covers one (sgn, mx MSB) quarter. The same run also exercises counter
//     saturation.
// Expected products come from plain integer multiplication.
// ---------------------------------------------------------------------------
module tb_mb_r8_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, sgn, out_valid, out_ready;
    logic [15:0] mx, my;
    logic [31:0] product;
    logic [15:0] done_cnt;

    logic        w8_in_valid  [4];
    logic        w8_in_ready  [4];
    logic        w8_sgn       [4];
    logic [7:0]  w8_mx        [4];
    logic [7:0]  w8_my        [4];
    logic        w8_out_valid [4];
    logic        w8_out_ready [4];
    logic [15:0] w8_product   [4];
    logic [3:0]  w8_done      [4];

    int n_checks = 0;
    int n_passed = 0;

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    mb_r8_pipe #(.WIDTH(16), .CNTW(16)) dut (
        .CLK       (clk),
        .RST       (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sgn       (sgn),
        .mx        (mx),
        .my        (my),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .done_cnt  (done_cnt)
    );

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_w8
            mb_r8_pipe #(.WIDTH(8), .CNTW(4)) dut8 (
                .CLK       (clk),
                .RST       (rst_n),
                .in_valid  (w8_in_valid[g]),
                .in_ready  (w8_in_ready[g]),
                .sgn       (w8_sgn[g]),
                .mx        (w8_mx[g]),
                .my        (w8_my[g]),
                .out_valid (w8_out_valid[g]),
                .out_ready (w8_out_ready[g]),
                .product   (w8_product[g]),
                .done_cnt  (w8_done[g])
            );
        end
    endgenerate

    // Reference multiply: interpret both operands as w-bit signed or
    // unsigned numbers and multiply them. Callers truncate to 2*w bits.
    function automatic longint ref_mul(input bit s, input longint a, input longint b, input int w);
        longint sa;
        longint sb;
        sa = a;
        sb = b;
        if (s && a[w-1]) sa = a - (longint'(1) << w);
        if (s && b[w-1]) sb = b - (longint'(1) << w);
        return sa * sb;
    endfunction

    // Sweep operand mapping: instance k fixes mx[7] = k[1]; index n walks
    // mx[6:0] and my.
    function automatic logic [7:0] sweep_mx(input int k, input int n);
        logic [7:0] v;
        v[7]   = k[1];
        v[6:0] = n[14:8];
        return v;
    endfunction

    // Pulse reset for one cycle with the main inputs idle
    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reset values while RST is low, then in_ready right after release
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
        else n_passed++;
        n_checks++;
        if (product !== 32'h0) $display("[TB] FAIL reset_product: got %h want 0", product);
        else n_passed++;
        n_checks++;
        if (done_cnt !== 16'h0) $display("[TB] FAIL reset_done_cnt: got %0d want 0", done_cnt);
        else n_passed++;
        n_checks++;
        if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready_low: got %b want 0", in_ready);
        else n_passed++;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL release_in_ready: got %b want 1", in_ready);
        else n_passed++;
    endtask

    // Unsigned maximum operands and exact 3-cycle latency
    task automatic test_unsigned_max();
        int cyc;
        @(negedge clk);
        in_valid = 1'b1;
        sgn      = 1'b0;
        mx       = 16'hFFFF;
        my       = 16'hFFFF;
        out_ready = 1'b1;
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            cyc++;
        end while (out_valid !== 1'b1 && cyc < 10);
        n_checks++;
        if (cyc != 3) $display("[TB] FAIL umax_latency: got %0d cycles want 3", cyc);
        else n_passed++;
        n_checks++;
        if (product !== 32'hFFFE0001) $display("[TB] FAIL umax_product: got %h want fffe0001", product);
        else n_passed++;
    endtask

    // Signed corner cases issued back-to-back; results appear on consecutive cycles
    task automatic test_back_to_back();
        logic [15:0] ax [3];
        logic [15:0] by [3];
        logic [31:0] ex [3];
        int k;
        ax[0] = 16'h8000; by[0] = 16'h8000; ex[0] = 32'h40000000;
        ax[1] = 16'hFFFF; by[1] = 16'h0001; ex[1] = 32'hFFFFFFFF;
        ax[2] = 16'h7FFF; by[2] = 16'h8000; ex[2] = 32'hC0008000;
        k = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            in_valid = (cyc < 3);
            if (cyc < 3) begin
                mx  = ax[cyc];
                my  = by[cyc];
                sgn = 1'b1;
            end
            #1;
            if (out_valid === 1'b1 && k < 3) begin
                n_checks++;
                if (cyc != k + 3) $display("[TB] FAIL b2b_timing_%0d: got cycle %0d want %0d", k, cyc, k + 3);
                else n_passed++;
                n_checks++;
                if (product !== ex[k]) $display("[TB] FAIL b2b_product_%0d: got %h want %h", k, product, ex[k]);
                else n_passed++;
                k++;
            end
        end
        n_checks++;
        if (k != 3) $display("[TB] FAIL b2b_count: got %0d want 3", k);
        else n_passed++;
    endtask

    // Ten random pairs with out_ready low in cycles 4..7
    task automatic test_stall();
        logic [31:0] expq [$];
        logic [15:0] ax [10];
        logic [15:0] by [10];
        bit          sx [10];
        int sent;
        int got;
        bit stall;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            ax[i] = 16'($urandom);
            by[i] = 16'($urandom);
            sx[i] = 1'($urandom_range(0, 1));
        end
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            @(negedge clk);
            stall     = (cyc >= 4 && cyc <= 7);
            out_ready = !stall;
            in_valid  = (sent < 10);
            if (sent < 10) begin
                mx  = ax[sent];
                my  = by[sent];
                sgn = sx[sent];
            end
            #1;
            n_checks++;
            if (in_ready !== !stall) $display("[TB] FAIL stall_in_ready_c%0d: got %b want %b", cyc, in_ready, !stall);
            else n_passed++;
            if (stall) begin
                n_checks++;
                if (out_valid !== 1'b1) $display("[TB] FAIL stall_out_valid_c%0d: got %b want 1", cyc, out_valid);
                else n_passed++;
            end
            if (out_valid === 1'b1) begin
                n_checks++;
                if (expq.size() == 0) begin
                    $display("[TB] FAIL stall_unexpected_output: got %h want none", product);
                end else if (product !== expq[0]) begin
                    $display("[TB] FAIL stall_product_%0d: got %h want %h", got, product, expq[0]);
                end else begin
                    n_passed++;
                end
                if (out_ready && expq.size() != 0) begin
                    void'(expq.pop_front());
                    got++;
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                expq.push_back(32'(ref_mul(sx[sent], ax[sent], by[sent], 16)));
                sent++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (got != 10) $display("[TB] FAIL stall_result_count: got %0d want 10", got);
        else n_passed++;
        @(negedge clk);
        n_checks++;
        if (done_cnt !== 16'd10) $display("[TB] FAIL stall_done_cnt: got %0d want 10", done_cnt);
        else n_passed++;
    endtask

    // Random valid/ready pattern, mixed sgn, 30 operations in order
    task automatic test_random_mix();
        logic [31:0] expq [$];
        logic [15:0] a;
        logic [15:0] b;
        bit s;
        int sent;
        int got;
        do_reset();
        a = 16'($urandom);
        b = 16'($urandom);
        s = 1'($urandom_range(0, 1));
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 400 && got < 30; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 30) && ($urandom_range(0, 3) != 0);
            mx  = a;
            my  = b;
            sgn = s;
            #1;
            if (out_valid === 1'b1) begin
                n_checks++;
                if (expq.size() == 0) begin
                    $display("[TB] FAIL mix_unexpected_output: got %h want none", product);
                end else if (product !== expq[0]) begin
                    $display("[TB] FAIL mix_product_%0d: got %h want %h", got, product, expq[0]);
                end else begin
                    n_passed++;
                end
                if (out_ready && expq.size() != 0) begin
                    void'(expq.pop_front());
                    got++;
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                expq.push_back(32'(ref_mul(s, a, b, 16)));
                sent++;
                a = 16'($urandom);
                b = 16'($urandom);
                s = 1'($urandom_range(0, 1));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (got != 30) $display("[TB] FAIL mix_result_count: got %0d want 30", got);
        else n_passed++;
        @(negedge clk);
        n_checks++;
        if (done_cnt !== 16'd30) $display("[TB] FAIL mix_done_cnt: got %0d want 30", done_cnt);
        else n_passed++;
    endtask

    // Reset with two operations in flight; nothing stale comes out afterwards
    task automatic test_reset_midflight();
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] e;
        int cyc;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        sgn = 1'b0;
        mx  = 16'($urandom);
        my  = 16'($urandom);
        @(negedge clk);
        mx  = 16'($urandom);
        my  = 16'($urandom);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL midrst_out_valid: got %b want 0", out_valid);
        else n_passed++;
        n_checks++;
        if (product !== 32'h0) $display("[TB] FAIL midrst_product: got %h want 0", product);
        else n_passed++;
        n_checks++;
        if (done_cnt !== 16'h0) $display("[TB] FAIL midrst_done_cnt: got %0d want 0", done_cnt);
        else n_passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || product !== 32'h0)
                $display("[TB] FAIL midrst_stale_%0d: got valid=%b product=%h want valid=0 product=0", i, out_valid, product);
            else n_passed++;
        end
        a = 16'($urandom);
        b = 16'($urandom);
        e = 32'(ref_mul(1'b1, a, b, 16));
        @(negedge clk);
        in_valid = 1'b1;
        sgn = 1'b1;
        mx  = a;
        my  = b;
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            cyc++;
        end while (out_valid !== 1'b1 && cyc < 10);
        n_checks++;
        if (cyc != 3) $display("[TB] FAIL midrst_latency: got %0d cycles want 3", cyc);
        else n_passed++;
        n_checks++;
        if (product !== e) $display("[TB] FAIL midrst_product_after: got %h want %h", product, e);
        else n_passed++;
    endtask

    // Exhaustive WIDTH=8 sweep over four instances. One comparison per
    // 256-product row, plus done_cnt saturation at 4 bits.
    task automatic test_w8_sweep();
        int sent    [4];
        int got     [4];
        int row_err [4];
        logic [15:0] bad_act [4];
        logic [15:0] bad_exp [4];
        logic [15:0] e;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  ed;
        int idx;
        bit all_done;
        for (int k = 0; k < 4; k++) begin
            sent[k]    = 0;
            got[k]     = 0;
            row_err[k] = 0;
            bad_act[k] = '0;
            bad_exp[k] = '0;
            w8_out_ready[k] = 1'b1;
        end
        for (int cyc = 0; cyc < 32800; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                w8_in_valid[k] = (sent[k] < 32768);
                w8_sgn[k]      = k[0];
                w8_mx[k]       = sweep_mx(k, sent[k]);
                w8_my[k]       = 8'(sent[k]);
            end
            #1;
            all_done = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (w8_out_valid[k] === 1'b1 && got[k] < 32768) begin
                    idx = got[k];
                    a   = sweep_mx(k, idx);
                    b   = 8'(idx);
                    e   = 16'(ref_mul(k[0], a, b, 8));
                    if (w8_product[k] !== e) begin
                        if (row_err[k] == 0) begin
                            bad_act[k] = w8_product[k];
                            bad_exp[k] = e;
                        end
                        row_err[k]++;
                    end
                    if (idx >= 14 && idx <= 17) begin
                        ed = (idx < 15) ? 4'(idx) : 4'd15;
                        n_checks++;
                        if (w8_done[k] !== ed) $display("[TB] FAIL w8_done_cnt_i%0d_n%0d: got %0d want %0d", k, idx, w8_done[k], ed);
                        else n_passed++;
                    end
                    got[k]++;
                    if (got[k] % 256 == 0) begin
                        n_checks++;
                        if (row_err[k] != 0)
                            $display("[TB] FAIL w8_row_i%0d_mx%h: %0d bad, first got %h want %h", k, a, row_err[k], bad_act[k], bad_exp[k]);
                        else n_passed++;
                        row_err[k] = 0;
                    end
                end
                if (w8_in_valid[k] && w8_in_ready[k] === 1'b1) sent[k]++;
                if (got[k] < 32768) all_done = 1'b0;
            end
            if (all_done) break;
        end
        for (int k = 0; k < 4; k++) begin
            w8_in_valid[k] = 1'b0;
            n_checks++;
            if (got[k] != 32768) $display("[TB] FAIL w8_result_count_i%0d: got %0d want 32768", k, got[k]);
            else n_passed++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sgn       = 1'b0;
        mx        = '0;
        my        = '0;
        for (int k = 0; k < 4; k++) begin
            w8_in_valid[k]  = 1'b0;
            w8_sgn[k]       = 1'b0;
            w8_mx[k]        = '0;
            w8_my[k]        = '0;
            w8_out_ready[k] = 1'b1;
        end
        $display("[TB] starting mb_r8_pipe bench");
        test_reset();
        test_unsigned_max();
        test_back_to_back();
        test_stall();
        test_random_mix();
        test_reset_midflight();
        test_w8_sweep();
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
